// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, FSM states and
// response error codes.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality/alignment, store byte lanes and
// load extraction/extension from a 32-bit dmem word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    output logic [31:0] mask,
    output logic [31:0] wd,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [3:0]  byte_en;
    logic [31:0] rd_shifted;

    always_comb begin
        if (we) begin
            illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        end else begin
            illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W) &&
                      (funct3 != F3_BU) && (funct3 != F3_HU);
        end
    end

    // Only evaluated for legal encodings, so funct3[1:0] alone gives the size.
    always_comb begin
        misalign = 1'b0;
        if (!illegal) begin
            case (funct3[1:0])
                2'b01:   misalign = off[0];
                2'b10:   misalign = (off != 2'b00);
                default: misalign = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << off;
                wd      = {24'd0, wdata[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                byte_en = 4'b0011 << off;
                wd      = {16'd0, wdata[15:0]} << {off, 3'b000};
            end
            default: begin
                byte_en = 4'b1111;
                wd      = wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign mask[8*gi +: 8] = {8{byte_en[gi]}};
        end
    endgenerate

    assign rd_shifted = rd >> {off, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_H:    load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_W:    load_data = rd;
            F3_BU:   load_data = {24'd0, rd_shifted[7:0]};
            F3_HU:   load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of dmem: one request at a time through an
// IDLE -> ACCESS -> RESP handshake FSM with registered dmem and response outputs.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_a,
    output logic [DATA_W-1:0] dmem_wd,
    output logic [DATA_W-1:0] dmem_write_mask,
    input  logic [DATA_W-1:0] dmem_rd
);

    state_t      state_reg;
    logic        we_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  off_reg;

    logic        idle;
    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [31:0] al_mask;
    logic [31:0] al_wd;
    logic        al_misalign;
    logic        al_illegal;
    logic [31:0] al_load_data;

    assign idle      = (state_reg == ST_IDLE);
    assign req_ready = idle;

    // The aligner decodes the live request in IDLE and the latched one in ACCESS.
    assign al_we     = idle ? req_we : we_reg;
    assign al_funct3 = idle ? req_funct3 : f3_reg;
    assign al_off    = idle ? req_addr[1:0] : off_reg;

    lsu_align u_align (
        .we        (al_we),
        .funct3    (al_funct3),
        .off       (al_off),
        .wdata     (req_wdata),
        .rd        (dmem_rd),
        .mask      (al_mask),
        .wd        (al_wd),
        .misalign  (al_misalign),
        .illegal   (al_illegal),
        .load_data (al_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            we_reg          <= 1'b0;
            f3_reg          <= 3'd0;
            off_reg         <= 2'd0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_err        <= ERR_OK;
            dmem_we         <= 1'b0;
            dmem_a          <= '0;
            dmem_wd         <= '0;
            dmem_write_mask <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg  <= req_we;
                        f3_reg  <= req_funct3;
                        off_reg <= req_addr[1:0];
                        if (al_illegal || al_misalign) begin
                            state_reg  <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= al_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        end else begin
                            state_reg       <= ST_ACCESS;
                            dmem_we         <= req_we;
                            dmem_a          <= {req_addr[ADDR_W-1:2], 2'b00};
                            dmem_wd         <= al_wd;
                            dmem_write_mask <= req_we ? al_mask : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_reg       <= ST_RESP;
                    dmem_we         <= 1'b0;
                    dmem_write_mask <= '0;
                    resp_valid      <= 1'b1;
                    resp_err        <= ERR_OK;
                    resp_rdata      <= we_reg ? '0 : al_load_data;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_reg  <= ST_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed vectors covering stores, loads,
// error paths, response back-pressure and reset during ACCESS.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        dmem_we;
    logic [31:0] dmem_a;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_write_mask;
    logic [31:0] dmem_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .dmem_we         (dmem_we),
        .dmem_a          (dmem_a),
        .dmem_wd         (dmem_wd),
        .dmem_write_mask (dmem_write_mask),
        .dmem_rd         (dmem_rd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request while IDLE and let the accepting edge pass.
    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    // Full load through ACCESS; checks extended data and error code.
    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rd, input logic [31:0] exp);
        dmem_rd = rd;
        send(1'b0, f3, addr, 32'h0);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_a"}, dmem_a, {addr[31:2], 2'b00});
        tick();
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_err"}, {30'd0, resp_err}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, exp);
        take_resp();
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_mask,
                         input logic [31:0] exp_wd);
        send(1'b1, f3, addr, wd);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
        check({tag, "_a"}, dmem_a, {addr[31:2], 2'b00});
        check({tag, "_mask"}, dmem_write_mask, exp_mask);
        check({tag, "_wd"}, dmem_wd, exp_wd);
        check({tag, "_valid_n1"}, {31'd0, resp_valid}, 32'd0);
        tick();
        check({tag, "_we_clr"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_mask_clr"}, dmem_write_mask, 32'd0);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_err"}, {30'd0, resp_err}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        take_resp();
    endtask

    // Error requests skip ACCESS: response is up one cycle after acceptance.
    task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [1:0] exp_err);
        dmem_rd = 32'hFFFF_FFFF;
        send(we, f3, addr, 32'hFFFF_FFFF);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_err"}, {30'd0, resp_err}, {30'd0, exp_err});
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        tick();
        check({tag, "_we_n2"}, {31'd0, dmem_we}, 32'd0);
        take_resp();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        dmem_rd    = 32'd0;
        #2;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_a", dmem_a, 32'd0);
        check("rst_mask", dmem_write_mask, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        store("sb_103", 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'hFF00_0000, 32'hAB00_0000);
        store("sh_102", 3'b001, 32'h0000_0102, 32'h0000_1234, 32'hFFFF_0000, 32'h1234_0000);
        store("sw_108", 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hCAFE_F00D);

        load("lb_102",  3'b000, 32'h0000_0102, 32'h0080_0000, 32'hFFFF_FF80);
        load("lbu_102", 3'b100, 32'h0000_0102, 32'h0080_0000, 32'h0000_0080);
        load("lh_102",  3'b001, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001);
        load("lhu_102", 3'b101, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001);
        load("lw_104",  3'b010, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678);

        bad("lh_101_mis",  1'b0, 3'b001, 32'h0000_0101, 2'b01);
        bad("lw_102_mis",  1'b0, 3'b010, 32'h0000_0102, 2'b01);
        bad("ld011_ill",   1'b0, 3'b011, 32'h0000_0101, 2'b10);
        bad("st100_ill",   1'b1, 3'b100, 32'h0000_0100, 2'b10);

        // Back-pressure: response held while a new request waits.
        dmem_rd = 32'h0000_00C3;
        send(1'b0, 3'b100, 32'h0000_0100, 32'h0);
        tick();
        dmem_rd    = 32'h5555_5555;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0200;
        req_wdata  = 32'hDEAD_BEEF;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'h0000_00C3);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
            check("hold_no_we", {31'd0, dmem_we}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("rel_valid", {31'd0, resp_valid}, 32'd0);
        check("rel_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("next_we", {31'd0, dmem_we}, 32'd1);
        check("next_a", dmem_a, 32'h0000_0200);
        check("next_mask", dmem_write_mask, 32'hFFFF_FFFF);
        check("next_wd", dmem_wd, 32'hDEAD_BEEF);
        tick();
        take_resp();

        // Reset asserted in the middle of a store's ACCESS cycle.
        send(1'b1, 3'b010, 32'h0000_0300, 32'h1111_2222);
        check("rstacc_we_before", {31'd0, dmem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstacc_we", {31'd0, dmem_we}, 32'd0);
        check("rstacc_mask", dmem_write_mask, 32'd0);
        check("rstacc_a", dmem_a, 32'd0);
        check("rstacc_wd", dmem_wd, 32'd0);
        check("rstacc_valid", {31'd0, resp_valid}, 32'd0);
        check("rstacc_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstrel_ready", {31'd0, req_ready}, 32'd1);
        check("rstrel_valid", {31'd0, resp_valid}, 32'd0);
        load("post_rst_lb", 3'b000, 32'h0000_0301, 32'h0000_7F00, 32'h0000_007F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
